// File: rtl/tdc_interval_calc.sv
// Nutt-method interval calculator for a TDC: capture, compute, then buffer results in a
// show-ahead FIFO with a valid/ready readout, overflow status and a write counter.
module tdc_interval_calc #(
  parameter int unsigned FINE_W     = 5,
  parameter int unsigned COARSE_W   = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RES_W      = COARSE_W + FINE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FINE_W-1:0]             bin_start,
  input  logic [FINE_W-1:0]             bin_stop,
  input  logic [COARSE_W-1:0]           coarse_count,
  input  logic                          done_in,
  output logic [RES_W:0]                out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          ovf_flag,
  input  logic                          clr_ovf,
  output logic [15:0]                   meas_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  // Stage 1: capture
  logic                cap_vld_q;
  logic [FINE_W-1:0]   cap_start_q, cap_stop_q;
  logic [COARSE_W-1:0] cap_coarse_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld_q    <= 1'b0;
      cap_start_q  <= '0;
      cap_stop_q   <= '0;
      cap_coarse_q <= '0;
    end else begin
      cap_vld_q <= done_in;
      if (done_in) begin
        cap_start_q  <= bin_start;
        cap_stop_q   <= bin_stop;
        cap_coarse_q <= coarse_count;
      end
    end
  end

  // Stage 2: compute
  logic [RES_W+1:0] raw;
  logic [RES_W:0]   comp_data_d, comp_data_q;
  logic             comp_vld_q;

  always_comb begin
    raw = {2'b00, cap_coarse_q, {FINE_W{1'b0}}}
        + {{(RES_W + 2 - FINE_W){1'b0}}, cap_start_q}
        - {{(RES_W + 2 - FINE_W){1'b0}}, cap_stop_q};
    // Non-negative results never reach the top two bits; any set bit means a negative raw.
    if (raw[RES_W+1:RES_W] != 2'b00) begin
      comp_data_d = {1'b1, {RES_W{1'b0}}};
    end else begin
      comp_data_d = {1'b0, raw[RES_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      comp_vld_q  <= 1'b0;
      comp_data_q <= '0;
    end else begin
      comp_vld_q <= cap_vld_q;
      if (cap_vld_q) comp_data_q <= comp_data_d;
    end
  end

  // Stage 3: FIFO with extra pointer MSB for full/empty
  logic [RES_W:0] mem_q [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic           empty, full, push, pop, drop;

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push      = comp_vld_q && (!full || pop);
    drop      = comp_vld_q && full && !pop;
    out_data  = mem_q[rd_ptr_q[AW-1:0]];
    fill_level = wr_ptr_q - rd_ptr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      meas_count <= '0;
      ovf_flag   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= comp_data_q;
        wr_ptr_q                <= wr_ptr_q + PtrOne;
        meas_count              <= meas_count + 16'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      // A drop outranks a coincident clear
      if (drop)         ovf_flag <= 1'b1;
      else if (clr_ovf) ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_interval_calc.sv
// Directed self-checking bench for tdc_interval_calc.
module tb_tdc_interval_calc;

  logic        clk;
  logic        reset;
  logic [4:0]  bin_start, bin_stop;
  logic [3:0]  coarse_count;
  logic        done_in;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fill_level;
  logic        ovf_flag;
  logic        clr_ovf;
  logic [15:0] meas_count;

  int tests;
  int failed;

  tdc_interval_calc #(
    .FINE_W    (5),
    .COARSE_W  (4),
    .FIFO_DEPTH(8),
    .RES_W     (9)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bin_start   (bin_start),
    .bin_stop    (bin_stop),
    .coarse_count(coarse_count),
    .done_in     (done_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fill_level  (fill_level),
    .ovf_flag    (ovf_flag),
    .clr_ovf     (clr_ovf),
    .meas_count  (meas_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input int s, input int p);
    coarse_count = 4'(c);
    bin_start    = 5'(s);
    bin_stop     = 5'(p);
    done_in      = 1'b1;
    step();
    done_in      = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset = 1'b0;
    bin_start = '0;
    bin_stop = '0;
    coarse_count = '0;
    done_in = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_ovf", 32'(ovf_flag), 0);
    chk("rst_count", 32'(meas_count), 0);
    reset = 1'b1;
    step();

    // Basic interval and N+3 latency: 3*32 + 20 - 5 = 111
    out_ready = 1'b1;
    send(3, 20, 5);
    chk("lat_n1", 32'(out_valid), 0);
    step();
    chk("lat_n2", 32'(out_valid), 0);
    step();
    chk("lat_n3", 32'(out_valid), 1);
    chk("basic_data", 32'(out_data), 111);
    chk("basic_count", 32'(meas_count), 1);
    step();
    chk("basic_empty", 32'(out_valid), 0);

    // Underflow, then the maximum interval
    send(0, 2, 10);
    send(15, 31, 0);
    step();
    chk("udf_valid", 32'(out_valid), 1);
    chk("udf_data", 32'(out_data), 512);
    step();
    chk("max_valid", 32'(out_valid), 1);
    chk("max_data", 32'(out_data), 511);
    step();
    chk("max_empty", 32'(out_valid), 0);
    chk("count3", 32'(meas_count), 3);

    // Overflow: 9 results into an 8-entry FIFO with no reads
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(i, i, 0);
    step();
    step();
    step();
    chk("ovf_fill", 32'(fill_level), 8);
    chk("ovf_flag", 32'(ovf_flag), 1);
    chk("ovf_count", 32'(meas_count), 11);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_valid", 32'(out_valid), 1);
      chk("ovf_drain_data", 32'(out_data), 32'(33 * i));
      step();
    end
    chk("ovf_drained", 32'(fill_level), 0);
    chk("ovf_sticky", 32'(ovf_flag), 1);
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clear", 32'(ovf_flag), 0);

    // Full FIFO with a pop coinciding with a push: nothing dropped
    for (int i = 0; i < 8; i++) send(1, i, 0);
    step();
    step();
    chk("full_fill", 32'(fill_level), 8);
    send(1, 8, 0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_fill_kept", 32'(fill_level), 8);
    chk("full_no_ovf", 32'(ovf_flag), 0);
    chk("full_count", 32'(meas_count), 20);
    chk("full_stable", 32'(out_data), 33);
    step();
    chk("full_hold", 32'(out_data), 33);
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk("full_order", 32'(out_data), 32'(32 + i));
      step();
    end
    chk("full_empty", 32'(out_valid), 0);

    // Back-to-back stream of 20 with out_ready held high
    for (int k = 0; k < 23; k++) begin
      if (k < 20) begin
        coarse_count = 4'((k % 15) + 1);
        bin_start    = 5'(k);
        bin_stop     = 5'd3;
        done_in      = 1'b1;
      end else begin
        done_in = 1'b0;
      end
      if (k < 3) begin
        chk("stream_lead", 32'(out_valid), 0);
      end else begin
        chk("stream_valid", 32'(out_valid), 1);
        chk("stream_data", 32'(out_data), 32'((((k - 3) % 15) + 1) * 32 + (k - 3) - 3));
      end
      step();
    end
    chk("stream_end", 32'(out_valid), 0);
    chk("stream_count", 32'(meas_count), 40);

    // Reset with 4 stored and 2 in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(2, i, 0);
    chk("pre_rst_fill", 32'(fill_level), 4);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_fill", 32'(fill_level), 0);
    chk("mid_rst_count", 32'(meas_count), 0);
    #2;
    reset = 1'b1;
    step();
    chk("post_rst_stale", 32'(out_valid), 0);
    out_ready = 1'b1;
    send(3, 20, 5);
    step();
    step();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 111);
    chk("post_rst_count", 32'(meas_count), 1);
    step();
    chk("post_rst_empty", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
